// File: rtl/pc_unit_if.sv
// Bundle between the controller/IM side and the program-counter unit.
// The master drives the next-PC controls and reads back PC state; the PC unit is the slave.
interface pc_unit_if #(
    parameter int WIDTH = 32
);
    logic              en;
    logic [1:0]        npc_sel;
    logic              br_taken;
    logic [15:0]       imm16;
    logic [25:0]       instr_index;
    logic [WIDTH-1:0]  jr_target;
    logic              exc_req;
    logic              eret;
    logic [WIDTH-1:0]  pc;
    logic [WIDTH-1:0]  pc_plus4;
    logic [WIDTH-1:0]  epc;
    logic              in_exc;
    logic              misalign;

    modport master (
        output en, npc_sel, br_taken, imm16, instr_index, jr_target, exc_req, eret,
        input  pc, pc_plus4, epc, in_exc, misalign
    );

    modport slave (
        input  en, npc_sel, br_taken, imm16, instr_index, jr_target, exc_req, eret,
        output pc, pc_plus4, epc, in_exc, misalign
    );
endinterface

// File: rtl/pc_unit.sv
// Program-counter unit for the single-cycle MIPS datapath.
// Holds PC and EPC, selects the next PC (seq/branch/jump/jr), and handles
// stall, exception entry, ERET and misaligned-jr trapping.
//
// state | meaning
// ------+----------------------------------------------------------
// RUN   | normal execution; exception entry captures EPC
// EXC   | inside handler; nested entries re-vector but keep EPC
module pc_unit #(
    parameter int               WIDTH    = 32,
    parameter logic [WIDTH-1:0] RESET_PC = WIDTH'(32'h0000_3000),
    parameter logic [WIDTH-1:0] EXC_PC   = WIDTH'(32'h0000_4180)
) (
    input  logic       clk,
    input  logic       reset,
    pc_unit_if.slave   bus
);

    localparam logic [1:0] SEL_SEQ    = 2'b00;
    localparam logic [1:0] SEL_BRANCH = 2'b01;
    localparam logic [1:0] SEL_JUMP   = 2'b10;
    localparam logic [1:0] SEL_JR     = 2'b11;

    typedef enum logic {
        RUN = 1'b0,
        EXC = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] pc_q, pc_d;
    logic [WIDTH-1:0] epc_q, epc_d;
    logic             misalign_q, misalign_d;

    logic [WIDTH-1:0] pc_plus4_w;
    logic [WIDTH-1:0] br_offset;
    logic [WIDTH-1:0] br_target;
    logic [WIDTH-1:0] jump_target;
    logic [WIDTH-1:0] sel_target;
    logic             jr_misaligned;

    // Candidate targets; all arithmetic wraps modulo 2^WIDTH.
    always_comb begin
        pc_plus4_w    = pc_q + WIDTH'(4);
        br_offset     = {{(WIDTH-18){bus.imm16[15]}}, bus.imm16, 2'b00};
        br_target     = bus.br_taken ? (pc_plus4_w + br_offset) : pc_plus4_w;
        jump_target   = {pc_plus4_w[WIDTH-1:28], bus.instr_index, 2'b00};
        jr_misaligned = (bus.jr_target[1:0] != 2'b00);
        unique case (bus.npc_sel)
            SEL_SEQ:    sel_target = pc_plus4_w;
            SEL_BRANCH: sel_target = br_target;
            SEL_JUMP:   sel_target = jump_target;
            SEL_JR:     sel_target = bus.jr_target;
            default:    sel_target = pc_plus4_w;
        endcase
    end

    // Next-state and next-register values, in per-cycle priority order.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        epc_d      = epc_q;
        misalign_d = 1'b0;
        if (!bus.en) begin
            // stall: everything holds, misalign pulse drops
        end else if (bus.exc_req) begin
            pc_d    = EXC_PC;
            state_d = EXC;
            if (state_q == RUN) begin
                epc_d = pc_q;
            end
        end else if (bus.eret && (state_q == EXC)) begin
            pc_d    = epc_q + WIDTH'(4);
            state_d = RUN;
        end else if ((bus.npc_sel == SEL_JR) && jr_misaligned) begin
            pc_d       = EXC_PC;
            misalign_d = 1'b1;
            state_d    = EXC;
            if (state_q == RUN) begin
                epc_d = pc_q;
            end
        end else begin
            pc_d = sel_target;
        end
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= RUN;
            pc_q       <= RESET_PC;
            epc_q      <= '0;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            epc_q      <= epc_d;
            misalign_q <= misalign_d;
        end
    end

    assign bus.pc       = pc_q;
    assign bus.pc_plus4 = pc_plus4_w;
    assign bus.epc      = epc_q;
    assign bus.in_exc   = (state_q == EXC);
    assign bus.misalign = misalign_q;

endmodule

// File: tb/tb_pc_unit.sv
// Scoreboard bench for pc_unit: the driver computes expected post-edge state
// with a behavioural model and queues it; the monitor pops and compares after each edge.
module tb_pc_unit;

    logic clk;
    logic reset;

    pc_unit_if #(.WIDTH(32)) bus ();

    pc_unit #(
        .WIDTH    (32),
        .RESET_PC (32'h0000_3000),
        .EXC_PC   (32'h0000_4180)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        int          id;
        logic [31:0] pc;
        logic [31:0] epc;
        logic        in_exc;
        logic        mis;
        bit          has_const;
        logic [31:0] const_pc;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;
    int   step_id  = 0;

    // behavioural reference state
    logic [31:0] m_pc;
    logic [31:0] m_epc;
    bit          m_exc;
    bit          m_mis;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    task automatic check(input string nm, input int id, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s step=%0d actual=%h required=%h", nm, id, act, req);
        end
    endtask

    // Apply one cycle of inputs, advance the model, queue expected post-edge values.
    task automatic step(input bit r, input bit e, input logic [1:0] sel, input bit br,
                        input logic [15:0] imm, input logic [25:0] idx, input logic [31:0] jr,
                        input bit exc, input bit er, input bit hc, input logic [31:0] cpc);
        exp_t x;
        logic [31:0] nxt;
        @(negedge clk);
        reset           = r;
        bus.en          = e;
        bus.npc_sel     = sel;
        bus.br_taken    = br;
        bus.imm16       = imm;
        bus.instr_index = idx;
        bus.jr_target   = jr;
        bus.exc_req     = exc;
        bus.eret        = er;

        if (!r) begin
            m_pc = 32'h3000; m_epc = 0; m_exc = 0; m_mis = 0;
        end else if (!e) begin
            m_mis = 0;
        end else if (exc) begin
            if (!m_exc) m_epc = m_pc;
            m_pc = 32'h4180; m_exc = 1; m_mis = 0;
        end else if (er && m_exc) begin
            m_pc = m_epc + 4; m_exc = 0; m_mis = 0;
        end else if (sel == 2'd3 && (jr % 4) != 0) begin
            if (!m_exc) m_epc = m_pc;
            m_pc = 32'h4180; m_exc = 1; m_mis = 1;
        end else begin
            case (sel)
                2'd0:    nxt = m_pc + 4;
                2'd1:    nxt = br ? m_pc + 4 + 32'($signed(imm)) * 4 : m_pc + 4;
                2'd2:    nxt = ((m_pc + 4) & 32'hF000_0000) + 32'(idx) * 4;
                default: nxt = jr;
            endcase
            m_pc = nxt; m_mis = 0;
        end

        step_id++;
        x.id        = step_id;
        x.pc        = m_pc;
        x.epc       = m_epc;
        x.in_exc    = m_exc;
        x.mis       = m_mis;
        x.has_const = hc;
        x.const_pc  = cpc;
        sb.push_back(x);
    endtask

    // Monitor: after every active edge, compare DUT state with the oldest expectation.
    initial begin
        exp_t x;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                x = sb.pop_front();
                check("pc",       x.id, bus.pc,                 x.pc);
                check("pc_plus4", x.id, bus.pc_plus4,           x.pc + 32'd4);
                check("epc",      x.id, bus.epc,                x.epc);
                check("in_exc",   x.id, {31'd0, bus.in_exc},    {31'd0, x.in_exc});
                check("misalign", x.id, {31'd0, bus.misalign},  {31'd0, x.mis});
                if (x.has_const)
                    check("pc_const", x.id, bus.pc, x.const_pc);
            end
        end
    end

    initial begin
        logic [31:0] jr;
        bit          r, e, exc, er;
        reset = 1'b0;
        bus.en = 1'b0; bus.npc_sel = 2'b00; bus.br_taken = 1'b0; bus.imm16 = '0;
        bus.instr_index = '0; bus.jr_target = '0; bus.exc_req = 1'b0; bus.eret = 1'b0;
        m_pc = 0; m_epc = 0; m_exc = 0; m_mis = 0;

        // reset, then sequential fetch
        step(0, 1, 0, 0, 16'h0, 26'h0, 32'h0, 0, 0, 1, 32'h3000);
        step(0, 1, 0, 0, 16'h0, 26'h0, 32'h0, 0, 0, 1, 32'h3000);
        step(1, 1, 0, 0, 16'h0, 26'h0, 32'h0, 0, 0, 1, 32'h3004);
        step(1, 1, 0, 0, 16'h0, 26'h0, 32'h0, 0, 0, 1, 32'h3008);
        // branch back by one word, then not-taken
        step(1, 1, 1, 1, 16'hFFFF, 26'h0, 32'h0, 0, 0, 1, 32'h3008);
        step(1, 1, 1, 0, 16'hFFFF, 26'h0, 32'h0, 0, 0, 1, 32'h300C);
        // jump
        step(1, 1, 2, 0, 16'h0, 26'h0000C40, 32'h0, 0, 0, 1, 32'h3100);
        // misaligned jr traps
        step(1, 1, 3, 0, 16'h0, 26'h0, 32'h3002, 0, 0, 1, 32'h4180);
        // nested exception keeps EPC, misalign drops
        step(1, 1, 0, 0, 16'h0, 26'h0, 32'h0, 1, 0, 1, 32'h4180);
        // eret returns to epc+4
        step(1, 1, 0, 0, 16'h0, 26'h0, 32'h0, 0, 1, 1, 32'h3104);
        // eret in RUN is ignored
        step(1, 1, 0, 0, 16'h0, 26'h0, 32'h0, 0, 1, 1, 32'h3108);
        // exception entry, stalled exception request, reset mid-EXC
        step(1, 1, 0, 0, 16'h0, 26'h0, 32'h0, 1, 0, 1, 32'h4180);
        step(1, 0, 3, 0, 16'h0, 26'h0, 32'h1, 1, 1, 1, 32'h4180);
        step(0, 1, 0, 0, 16'h0, 26'h0, 32'h0, 1, 0, 1, 32'h3000);
        // aligned jr, exc_req beats misaligned trap
        step(1, 1, 3, 0, 16'h0, 26'h0, 32'h0000_5000, 0, 0, 1, 32'h5000);
        step(1, 1, 3, 0, 16'h0, 26'h0, 32'h0000_5003, 1, 0, 1, 32'h4180);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            r   = ($urandom_range(0, 63) != 0);
            e   = ($urandom_range(0, 7) != 0);
            exc = ($urandom_range(0, 15) == 0);
            er  = ($urandom_range(0, 5) == 0);
            jr  = $urandom;
            if ($urandom_range(0, 1) == 0) jr[1:0] = 2'b00;
            step(r, e, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 16'($urandom),
                 26'($urandom), jr, exc, er, 0, 32'h0);
        end

        repeat (3) @(posedge clk);
        #2;
        check("drain", step_id, 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
